// File: rtl/axis_output_packer.sv
// Output packer: buffers 128-bit PPU vectors in a small FIFO and streams each
// vector as two 64-bit AXI4-Stream beats (low half first), with TLAST per packet.
module axis_output_packer #(
  parameter int IN_WIDTH   = 128,
  parameter int OUT_WIDTH  = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_valid,
  input  logic [IN_WIDTH-1:0]           i_data,
  input  logic [CNT_WIDTH-1:0]          cfg_vecs_per_pkt,
  output logic [OUT_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  output logic                          o_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_EMPTY, S_LO, S_HI} state_t;

  logic [IN_WIDTH-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [LW-1:0]                 level;
  state_t                        state;
  logic [IN_WIDTH-OUT_WIDTH-1:0] vec_q_hi;
  logic [CNT_WIDTH-1:0]          vec_cnt;
  logic                          pop, push, last_vec;

  // Pop whenever the holding register is (or is about to become) free; accept
  // a write if there is room or a slot is freed by the same-cycle pop.
  always_comb begin
    pop      = (level != '0) &&
               ((state == S_EMPTY) || ((state == S_HI) && m_axis_tready));
    push     = i_valid && ((level != LW'(FIFO_DEPTH)) || pop);
    last_vec = (cfg_vecs_per_pkt != '0) &&
               (vec_cnt == cfg_vecs_per_pkt - CNT_WIDTH'(1));
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push && !i_clear)
      mem[wr_ptr] <= i_data;
  end

  // FIFO pointers, level and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
      if (i_valid && !push)
        o_overflow <= 1'b1;
    end
  end

  // Serialiser FSM with registered stream outputs and packet counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_EMPTY;
      vec_q_hi      <= '0;
      vec_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (i_clear) begin
      state         <= S_EMPTY;
      vec_q_hi      <= '0;
      vec_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (pop) begin
            vec_q_hi      <= mem[rd_ptr][IN_WIDTH-1:OUT_WIDTH];
            m_axis_tdata  <= mem[rd_ptr][OUT_WIDTH-1:0];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            state         <= S_LO;
          end
        end
        S_LO: begin
          if (m_axis_tready) begin
            m_axis_tdata <= vec_q_hi;
            m_axis_tlast <= last_vec;
            state        <= S_HI;
          end
        end
        S_HI: begin
          if (m_axis_tready) begin
            vec_cnt <= m_axis_tlast ? '0 : vec_cnt + CNT_WIDTH'(1);
            if (pop) begin
              vec_q_hi      <= mem[rd_ptr][IN_WIDTH-1:OUT_WIDTH];
              m_axis_tdata  <= mem[rd_ptr][OUT_WIDTH-1:0];
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b0;
              state         <= S_LO;
            end else begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              state         <= S_EMPTY;
            end
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Status outputs.
  always_comb begin
    o_fifo_level = level;
    o_idle       = (level == '0) && (state == S_EMPTY);
  end

endmodule

// File: tb/tb_axis_output_packer.sv
// Bench for axis_output_packer: queue-based reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_axis_output_packer;

  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_clear = 1'b0;
  logic          i_valid = 1'b0;
  logic [127:0]  i_data = '0;
  logic [15:0]   cfg = 16'd1;
  logic [63:0]   tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic [3:0]    level;
  logic          ovf;
  logic          idle;

  axis_output_packer #(
    .IN_WIDTH  (128),
    .OUT_WIDTH (64),
    .FIFO_DEPTH(D),
    .CNT_WIDTH (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (i_clear),
    .i_valid         (i_valid),
    .i_data          (i_data),
    .cfg_vecs_per_pkt(cfg),
    .m_axis_tdata    (tdata),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (tready),
    .m_axis_tlast    (tlast),
    .o_fifo_level    (level),
    .o_overflow      (ovf),
    .o_idle          (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: vectors waiting in the FIFO, beats still owed for the
  // vector currently being streamed, and packet position of the next vector.
  logic [127:0] mq[$];
  logic [63:0]  pd[$];
  logic         pl[$];
  logic         m_ovf = 1'b0;
  int unsigned  m_idx = 0;
  int           beat_cnt = 0;
  int           tl_pos[$];
  logic [127:0] mv;
  bit           m_last;

  always @(posedge clk or posedge rst) begin
    if (rst || i_clear) begin
      mq.delete();
      pd.delete();
      pl.delete();
      m_ovf = 1'b0;
      m_idx = 0;
    end else begin
      if (pd.size() > 0 && tready) begin
        beat_cnt++;
        if (pl[0]) tl_pos.push_back(beat_cnt);
        void'(pd.pop_front());
        void'(pl.pop_front());
      end
      if (pd.size() == 0 && mq.size() > 0) begin
        mv = mq.pop_front();
        m_last = (cfg == 16'd0) ? 1'b0 : ((m_idx % 32'(cfg)) == 32'(cfg) - 1);
        pd.push_back(mv[63:0]);   pl.push_back(1'b0);
        pd.push_back(mv[127:64]); pl.push_back(m_last);
        m_idx++;
      end
      if (i_valid) begin
        if (mq.size() < D) mq.push_back(i_data);
        else m_ovf = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("tvalid", tvalid, pd.size() > 0);
      if (pd.size() > 0) begin
        chk("tdata", tdata, pd[0]);
        chk("tlast", tlast, pl[0]);
      end
      chk("level", level, mq.size());
      chk("overflow", ovf, m_ovf);
      chk("idle", idle, (mq.size() == 0) && (pd.size() == 0));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
  endtask

  task automatic drain();
    tready = 1'b1;
    i_valid = 1'b0;
    for (int i = 0; i < 500 && !idle; i++) step();
    chk("drain_idle", idle, 1'b1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] v0;
  int tl_base, beat_base, sent, cyc;

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_level", level, 4'd0);

    // One vector, cfg=1: LO beat one cycle after the write edge, then HI with TLAST.
    cfg = 16'd1;
    tready = 1'b1;
    i_valid = 1'b1;
    i_data = 128'h0F0E0D0C0B0A09080706050403020100;
    step();
    i_valid = 1'b0;
    chk("lat_tvalid_low", tvalid, 1'b0);
    step();
    chk("lat_tvalid_high", tvalid, 1'b1);
    chk("lo_beat", tdata, 64'h0706050403020100);
    chk("lo_tlast", tlast, 1'b0);
    step();
    chk("hi_beat", tdata, 64'h0F0E0D0C0B0A0908);
    chk("hi_tlast", tlast, 1'b1);
    drain();

    // Eight back-to-back vectors, cfg=4: TLAST on beats 8 and 16.
    cfg = 16'd4;
    do_clear();
    tl_base = tl_pos.size();
    beat_base = beat_cnt;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1;
      i_data = rnd128();
      step();
    end
    i_valid = 1'b0;
    drain();
    chk("burst_beats", beat_cnt - beat_base, 16);
    chk("burst_tlasts", tl_pos.size() - tl_base, 2);
    if (tl_pos.size() - tl_base == 2) begin
      chk("burst_tlast1", tl_pos[tl_base] - beat_base, 8);
      chk("burst_tlast2", tl_pos[tl_base+1] - beat_base, 16);
    end

    // Stall: ten pulses with tready low fill vec_q plus 8 FIFO entries, one drop.
    cfg = 16'd1;
    do_clear();
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1;
      i_data = rnd128();
      if (i == 0) v0 = i_data;
      step();
    end
    i_valid = 1'b0;
    repeat (10) step();
    chk("stall_level", level, 4'd8);
    chk("stall_overflow", ovf, 1'b1);
    chk("stall_hold", tdata, v0[63:0]);
    chk("stall_tvalid", tvalid, 1'b1);
    drain();
    chk("overflow_sticky", ovf, 1'b1);
    do_clear();
    chk("overflow_cleared", ovf, 1'b0);

    // Random backpressure, 100 vectors, cfg=5 -> 20 packets.
    cfg = 16'd5;
    do_clear();
    tl_base = tl_pos.size();
    beat_base = beat_cnt;
    sent = 0;
    cyc = 0;
    while (sent < 100 && cyc < 5000) begin
      tready = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1 && mq.size() < D) begin
        i_valid = 1'b1;
        i_data = rnd128();
        sent++;
      end else begin
        i_valid = 1'b0;
      end
      step();
      cyc++;
    end
    chk("rand_sent", sent, 100);
    drain();
    chk("rand_beats", beat_cnt - beat_base, 200);
    chk("rand_tlasts", tl_pos.size() - tl_base, 20);
    chk("rand_no_overflow", ovf, 1'b0);

    // Clear with a same-cycle write at level 3.
    cfg = 16'd1;
    do_clear();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1;
      i_data = rnd128();
      step();
    end
    chk("pre_clear_level", level, 4'd3);
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data = rnd128();
    step();
    i_clear = 1'b0;
    i_valid = 1'b0;
    chk("clear_level", level, 4'd0);
    chk("clear_tvalid", tvalid, 1'b0);
    chk("clear_overflow", ovf, 1'b0);
    chk("clear_idle", idle, 1'b1);
    step();
    chk("clear_stays_empty", tvalid, 1'b0);

    // Asynchronous reset mid-stream with overflow set.
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1;
      i_data = rnd128();
      step();
    end
    i_valid = 1'b0;
    chk("pre_rst_overflow", ovf, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", tvalid, 1'b0);
    chk("arst_tlast", tlast, 1'b0);
    chk("arst_level", level, 4'd0);
    chk("arst_idle", idle, 1'b1);
    chk("arst_overflow", ovf, 1'b0);
    step();
    rst = 1'b0;
    tready = 1'b1;
    repeat (3) step();
    chk("post_rst_tvalid", tvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached before end of test");
    $fatal(1);
  end

endmodule
